stopwatch_core: RTL

STOPWATCH_CORE -- requirements
Module: stopwatch_core

---
 rtl/stopwatch_core_pkg.sv | 31 +++
 rtl/stopwatch_core_tick_divider.sv | 44 ++++
 rtl/stopwatch_core.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/stopwatch_core_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : stopwatch_core_pkg
//  Purpose  : Shared definitions for the stopwatch core and the downstream
//             image drawer: FSM state encoding, display field widths and
//             the per-field wrap limits.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package stopwatch_core_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      PAUSED = 2'd2
   } sw_state_t;

   // Display field widths, also consumed by the image drawer.
   localparam int HR_W  = 4;
   localparam int MIN_W = 6;
   localparam int SEC_W = 6;
   localparam int MS_W  = 10;

   // Last legal value of each field before it wraps to zero.
   localparam logic [MS_W-1:0]  MS_MAX  = 10'd999;
   localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;
   localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;
   localparam logic [HR_W-1:0]  HR_MAX  = 4'd9;

endpackage
`default_nettype wire

// File: rtl/stopwatch_core_tick_divider.sv
`default_nettype none
// ============================================================================
//  Module   : tick_divider
//  Purpose  : Divides the system clock down to the millisecond tick. The
//             counter advances only while enabled and simply holds its
//             value otherwise, so a paused stopwatch keeps its partial
//             period.
//  Ports    : clk    - system clock, rising edge
//             reset  - synchronous active-high reset
//             enable - count while high
//             clear  - synchronous zero of the counter
//             tick   - high for the cycle whose edge completes a period
//  Revision : 1.0 - initial release
// ============================================================================
module tick_divider
   import stopwatch_core_pkg::*;
#(
   parameter int DIV = 4
)(
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic clear,
   output logic tick
);

   localparam int              CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= '0;
      end else if (enable) begin
         count <= (count == LAST) ? '0 : count + 1'b1;
      end
   end

   // Qualified by enable so a held counter at LAST never produces a tick.
   assign tick = enable & (count == LAST);

endmodule
`default_nettype wire

// File: rtl/stopwatch_core.sv
`default_nettype none
// ============================================================================
//  Module   : stopwatch_core
//  Purpose  : Millisecond stopwatch, 0:00:00.000 .. 9:59:59.999, with
//             run/pause, clear, lap freeze and sticky overflow.
//  Ports    : clk, reset          - clock / synchronous active-high reset
//             start_stop          - rising edge toggles run / pause
//             clear               - rising edge zeroes and stops
//             lap                 - rising edge toggles display freeze
//             hours, minutes,
//             seconds,
//             milliseconds        - registered displayed time
//             running             - high in RUN
//             lap_active          - high while the display is frozen
//             overflow            - sticky, set on wrap past 9:59:59.999
//  Revision : 1.0 - initial release
// ============================================================================
module stopwatch_core
   import stopwatch_core_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 50000000,
   parameter int TICK_HZ     = 1000
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             start_stop,
   input  logic             clear,
   input  logic             lap,
   output logic [HR_W-1:0]  hours,
   output logic [MIN_W-1:0] minutes,
   output logic [SEC_W-1:0] seconds,
   output logic [MS_W-1:0]  milliseconds,
   output logic             running,
   output logic             lap_active,
   output logic             overflow
);

   localparam int DIV = CLK_FREQ_HZ / TICK_HZ;

   logic             start_stop_q, clear_q, lap_q;
   logic             armed;
   logic             start_stop_rise, clear_rise, lap_rise;
   sw_state_t        state;
   logic             div_enable;
   logic             tick;
   logic [HR_W-1:0]  live_hr;
   logic [MIN_W-1:0] live_min;
   logic [SEC_W-1:0] live_sec;
   logic [MS_W-1:0]  live_ms;

   // Input history. 'armed' masks the first cycle after reset so a level
   // that is already high at release is not mistaken for a new edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         start_stop_q <= 1'b0;
         clear_q      <= 1'b0;
         lap_q        <= 1'b0;
         armed        <= 1'b0;
      end else begin
         start_stop_q <= start_stop;
         clear_q      <= clear;
         lap_q        <= lap;
         armed        <= 1'b1;
      end
   end

   assign start_stop_rise = armed & start_stop & ~start_stop_q;
   assign clear_rise      = armed & clear      & ~clear_q;
   assign lap_rise        = armed & lap        & ~lap_q;

   // Run/pause state machine; clear overrides any start_stop edge.
   always_ff @(posedge clk) begin
      if (reset || clear_rise) begin
         state   <= IDLE;
         running <= 1'b0;
      end else if (start_stop_rise) begin
         case (state)
            RUN: begin
               state   <= PAUSED;
               running <= 1'b0;
            end
            default: begin
               state   <= RUN;
               running <= 1'b1;
            end
         endcase
      end
   end

   assign div_enable = (state == RUN);

   tick_divider #(
      .DIV    (DIV)
   ) u_tick_divider (
      .clk    (clk),
      .reset  (reset),
      .enable (div_enable),
      .clear  (clear_rise),
      .tick   (tick)
   );

   // Live count, display registers and lap freeze. The display loads the
   // pre-edge live value whenever it is not frozen; a freezing lap edge
   // takes that same load, and an unfreezing lap edge forces it.
   always_ff @(posedge clk) begin
      if (reset || clear_rise) begin
         live_hr      <= '0;
         live_min     <= '0;
         live_sec     <= '0;
         live_ms      <= '0;
         hours        <= '0;
         minutes      <= '0;
         seconds      <= '0;
         milliseconds <= '0;
         lap_active   <= 1'b0;
         overflow     <= 1'b0;
      end else begin
         // Full carry chain resolves within one edge.
         if (tick) begin
            if (live_ms == MS_MAX) begin
               live_ms <= '0;
               if (live_sec == SEC_MAX) begin
                  live_sec <= '0;
                  if (live_min == MIN_MAX) begin
                     live_min <= '0;
                     if (live_hr == HR_MAX) begin
                        live_hr  <= '0;
                        overflow <= 1'b1;
                     end else begin
                        live_hr <= live_hr + 1'b1;
                     end
                  end else begin
                     live_min <= live_min + 1'b1;
                  end
               end else begin
                  live_sec <= live_sec + 1'b1;
               end
            end else begin
               live_ms <= live_ms + 1'b1;
            end
         end

         if (!lap_active || lap_rise) begin
            hours        <= live_hr;
            minutes      <= live_min;
            seconds      <= live_sec;
            milliseconds <= live_ms;
         end

         // Unfreeze from any state; freeze only while running.
         if (lap_rise) begin
            lap_active <= ~lap_active & (state == RUN);
         end
      end
   end

endmodule
`default_nettype wire
